// File: rtl/seg_display_encoder.sv
// Three-digit 7-segment encoder with shadow digit latch, leading-zero blanking,
// a min:sec decimal point and a blink mode. All outputs are registered.
module seg_display_encoder #(
  parameter int BLINK_HALF = 500,
  parameter int CW         = 10
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [3:0] DIG_M,
  input  logic [3:0] DIG_ST,
  input  logic [3:0] DIG_SO,
  input  logic       LOAD,
  input  logic       BLINK_EN,
  input  logic       BLANK_LZ,
  input  logic       DP_EN,
  output logic [7:0] SEG_B,
  output logic [7:0] SEG_C,
  output logic [7:0] SEG_D,
  output logic       SEG_UPD,
  output logic       BLINK_PH
);

  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);

  logic [3:0]    dig_m_q, dig_m_d;
  logic [3:0]    dig_st_q, dig_st_d;
  logic [3:0]    dig_so_q, dig_so_d;
  logic          load_seen_q, load_seen_d;
  logic          seg_upd_q, seg_upd_d;
  logic          blink_en_q, blink_en_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [7:0]    seg_b_q, seg_b_d;
  logic [7:0]    seg_c_q, seg_c_d;
  logic [7:0]    seg_d_q, seg_d_d;

  // Segment order {a,b,c,d,e,f,g,dp}; non-BCD codes show a dash.
  function automatic logic [7:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 8'b11111100;
      4'd1:    enc = 8'b01100000;
      4'd2:    enc = 8'b11011010;
      4'd3:    enc = 8'b11110010;
      4'd4:    enc = 8'b01100110;
      4'd5:    enc = 8'b10110110;
      4'd6:    enc = 8'b10111110;
      4'd7:    enc = 8'b11100000;
      4'd8:    enc = 8'b11111110;
      4'd9:    enc = 8'b11110110;
      default: enc = 8'b00000010;
    endcase
  endfunction

  always_comb begin
    dig_m_d  = dig_m_q;
    dig_st_d = dig_st_q;
    dig_so_d = dig_so_q;
    if (LOAD) begin
      dig_m_d  = DIG_M;
      dig_st_d = DIG_ST;
      dig_so_d = DIG_SO;
    end
    load_seen_d = LOAD;
    seg_upd_d   = load_seen_q;
    blink_en_d  = BLINK_EN;

    // Counter only runs once enable was already high, so a fresh enable starts a full on-phase.
    blink_cnt_d = '0;
    blink_ph_d  = 1'b1;
    if (BLINK_EN && blink_en_q) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CW'(1);
        blink_ph_d  = blink_ph_q;
      end
    end

    seg_b_d = 8'h00;
    seg_c_d = 8'h00;
    seg_d_d = 8'h00;
    if (blink_ph_d) begin
      seg_b_d    = (BLANK_LZ && dig_m_q == 4'd0) ? 8'h00 : enc(dig_m_q);
      seg_b_d[0] = DP_EN;
      seg_c_d    = enc(dig_st_q);
      seg_d_d    = enc(dig_so_q);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      dig_m_q     <= '0;
      dig_st_q    <= '0;
      dig_so_q    <= '0;
      load_seen_q <= 1'b0;
      seg_upd_q   <= 1'b0;
      blink_en_q  <= 1'b0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
      seg_b_q     <= 8'h00;
      seg_c_q     <= 8'h00;
      seg_d_q     <= 8'h00;
    end else begin
      dig_m_q     <= dig_m_d;
      dig_st_q    <= dig_st_d;
      dig_so_q    <= dig_so_d;
      load_seen_q <= load_seen_d;
      seg_upd_q   <= seg_upd_d;
      blink_en_q  <= blink_en_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      seg_b_q     <= seg_b_d;
      seg_c_q     <= seg_c_d;
      seg_d_q     <= seg_d_d;
    end
  end

  assign SEG_B    = seg_b_q;
  assign SEG_C    = seg_c_q;
  assign SEG_D    = seg_d_q;
  assign SEG_UPD  = seg_upd_q;
  assign BLINK_PH = blink_ph_q;

endmodule
